// File: rtl/sos_multichannel_dist_calc.sv
// sos_multichannel_dist_calc
// Multi-channel speed-of-sound distance calculator. A trigger requests one
// impulse from the external generator; once the impulse has been emitted,
// every microphone channel runs windowed-energy transient detection and the
// per-channel onset delay (in sample periods) is reported.
//
// Ports:
//   clk_in              system clock
//   rst_in              synchronous active-high reset
//   step_in             one-cycle sample strobe qualifying mic_in
//   trigger_in          start a measurement (honoured only when idle)
//   mic_in              packed signed samples, channel c at [c*MIC_WIDTH +: MIC_WIDTH]
//   impulse_trigger_out one-cycle request to the impulse generator
//   impulse_done_in     one-cycle pulse when the impulse has been emitted
//   delay_out           packed per-channel onset delays
//   delay_valid_out     per-channel onset-found flags
//   done_out            one-cycle pulse when results are updated
//   busy_out            high whenever a measurement is in progress
module sos_multichannel_dist_calc #(
  parameter int NUM_CH      = 4,
  parameter int MIC_WIDTH   = 8,
  parameter int WINDOW_SIZE = 16,
  parameter int MAX_DELAY   = 256,
  parameter int MIN_ENERGY  = 64,
  parameter int DELAY_W     = $clog2(MAX_DELAY)
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        step_in,
  input  logic                        trigger_in,
  input  logic [NUM_CH*MIC_WIDTH-1:0] mic_in,
  output logic                        impulse_trigger_out,
  input  logic                        impulse_done_in,
  output logic [NUM_CH*DELAY_W-1:0]   delay_out,
  output logic [NUM_CH-1:0]           delay_valid_out,
  output logic                        done_out,
  output logic                        busy_out
);

  localparam int WIN_BITS = $clog2(WINDOW_SIZE);
  localparam int ACC_W    = MIC_WIDTH + WIN_BITS;
  localparam logic [DELAY_W-1:0] LAST_K   = DELAY_W'(MAX_DELAY - 1);
  localparam logic [DELAY_W-1:0] WIN_BACK = DELAY_W'(WINDOW_SIZE - 1);
  localparam logic [ACC_W:0]     MIN_E    = (ACC_W + 1)'(MIN_ENERGY);

  typedef enum logic [2:0] {IDLE, FIRE, WAIT_IMP, ANALYZE, REPORT} state_t;

  state_t             state;
  logic [DELAY_W-1:0] k;
  logic [ACC_W-1:0]   acc  [NUM_CH];
  logic [ACC_W-1:0]   prev [NUM_CH];
  logic [ACC_W-1:0]   pp   [NUM_CH];
  logic [NUM_CH-1:0]  det;
  logic [DELAY_W-1:0] dly  [NUM_CH];

  logic                 eval;
  logic                 last_step;
  logic [NUM_CH-1:0]    onset;
  logic [NUM_CH-1:0]    det_nx;
  logic [MIC_WIDTH-1:0] smp  [NUM_CH];
  logic [MIC_WIDTH-1:0] mag  [NUM_CH];
  logic [ACC_W-1:0]     cur  [NUM_CH];
  logic [DELAY_W-1:0]   dly_nx [NUM_CH];

  // Per-channel window arithmetic. The next detected flags and delays are
  // computed here so the result registers can be loaded on the same edge
  // that finishes the analysis, making them visible together with done_out.
  // The 1.5x term is formed one bit wider than the window sums.
  always_comb begin
    eval = (state == ANALYZE) && step_in &&
           (k[WIN_BITS-1:0] == {WIN_BITS{1'b1}});
    for (int c = 0; c < NUM_CH; c++) begin
      smp[c]    = mic_in[c*MIC_WIDTH +: MIC_WIDTH];
      mag[c]    = smp[c][MIC_WIDTH-1] ? (~smp[c] + MIC_WIDTH'(1)) : smp[c];
      cur[c]    = acc[c] + ACC_W'(mag[c]);
      onset[c]  = (cur[c] > prev[c]) &&
                  ({1'b0, cur[c]} > ({1'b0, pp[c]} + ({1'b0, pp[c]} >> 1))) &&
                  ({1'b0, cur[c]} >= MIN_E);
      det_nx[c] = det[c] | (eval & onset[c]);
      dly_nx[c] = (eval && !det[c] && onset[c]) ? (k - WIN_BACK) : dly[c];
    end
    last_step = (state == ANALYZE) && step_in && ((k == LAST_K) || (&det_nx));
  end

  // Measurement sequencer. A detection on the final sample still counts
  // because the report is loaded from the next-state flags.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state               <= IDLE;
      k                   <= '0;
      det                 <= '0;
      impulse_trigger_out <= 1'b0;
      delay_out           <= '0;
      delay_valid_out     <= '0;
      done_out            <= 1'b0;
      busy_out            <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        acc[c]  <= '0;
        prev[c] <= '0;
        pp[c]   <= '0;
        dly[c]  <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          delay_valid_out <= '0;
          if (trigger_in) begin
            state               <= FIRE;
            impulse_trigger_out <= 1'b1;
            busy_out            <= 1'b1;
          end
        end
        FIRE: begin
          impulse_trigger_out <= 1'b0;
          state               <= WAIT_IMP;
        end
        WAIT_IMP: begin
          if (impulse_done_in) begin
            k     <= '0;
            det   <= '0;
            state <= ANALYZE;
            for (int c = 0; c < NUM_CH; c++) begin
              acc[c]  <= '0;
              prev[c] <= '0;
              pp[c]   <= '0;
              dly[c]  <= '0;
            end
          end
        end
        ANALYZE: begin
          if (step_in) begin
            k   <= k + DELAY_W'(1);
            det <= det_nx;
            for (int c = 0; c < NUM_CH; c++) begin
              dly[c] <= dly_nx[c];
              if (!det[c]) begin
                if (eval) begin
                  if (!onset[c]) begin
                    pp[c]   <= prev[c];
                    prev[c] <= cur[c];
                    acc[c]  <= '0;
                  end
                end else begin
                  acc[c] <= cur[c];
                end
              end
            end
            if (last_step) begin
              state           <= REPORT;
              done_out        <= 1'b1;
              delay_valid_out <= det_nx;
              for (int c = 0; c < NUM_CH; c++) begin
                delay_out[c*DELAY_W +: DELAY_W] <= det_nx[c] ? dly_nx[c] : '0;
              end
            end
          end
        end
        REPORT: begin
          done_out <= 1'b0;
          busy_out <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sos_multichannel_dist_calc.md
# sos_multichannel_dist_calc

Multi-channel speed-of-sound distance calculator, the parametrised successor to the single-mic calculator. One trigger requests a single impulse from the external impulse generator. The block then runs windowed-energy transient detection independently on `NUM_CH` microphone channels and reports a per-channel onset delay in 24 kHz sample periods. It sits between the mic front-end (decimated samples qualified by `step_in`) and the position/placement logic that consumes the per-channel delays.

## Interface
Parameters:
- `NUM_CH`, 4: number of microphone channels.
- `MIC_WIDTH`, 8: signed two's-complement sample width per channel.
- `WINDOW_SIZE`, 16: samples per energy window. Must be a power of two, ≥2.
- `MAX_DELAY`, 256: samples analysed before timeout. Must be a multiple of `WINDOW_SIZE`.
- `MIN_ENERGY`, 64: minimum window sum for a window to count as an onset.
- `DELAY_W`, `$clog2(MAX_DELAY)`: width of each reported delay.

Ports:
- `clk_in`  in  1  system clock; the only clock.
- `rst_in`  in  1  synchronous, active-high reset.
- `step_in`  in  1  one-cycle sample strobe (24 kHz).
- `trigger_in`  in  1  start a measurement; honoured only in IDLE.
- `mic_in`  in  `NUM_CH*MIC_WIDTH`  packed signed samples; channel c is at `[c*MIC_WIDTH +: MIC_WIDTH]`. Valid when `step_in`=1.
- `impulse_trigger_out`  out  1  one-cycle request to the impulse generator.
- `impulse_done_in`  in  1  one-cycle pulse from the generator when the impulse has been emitted.
- `delay_out`  out  `NUM_CH*DELAY_W`  packed per-channel delays.
- `delay_valid_out`  out  `NUM_CH`  per-channel onset-found flags.
- `done_out`  out  1  one-cycle pulse when results are updated.
- `busy_out`  out  1  high in any state other than IDLE.

## Operation
States:
- **IDLE**
  - `trigger_in`=1 → FIRE.
  - Clears `delay_valid_out` to 0. `delay_out` holds its previous value.
- **FIRE**
  - `impulse_trigger_out`=1 for exactly this cycle.
  - Next state is WAIT_IMP unconditionally.
- **WAIT_IMP**
  - Waits for `impulse_done_in`; no timeout.
  - On `impulse_done_in`: clear the sample counter, all accumulators and all window history, plus the internal per-channel detected flags. Then → ANALYZE.
- **ANALYZE**
  - On each `step_in`, sample index k (0-based, counted from ANALYZE entry) is processed.
  - Each not-yet-detected channel adds `|x|` to its accumulator.
- **REPORT**
  - `done_out`=1 for this cycle.
  - `delay_out` and `delay_valid_out` are loaded from the internal per-channel results.
  - Next state is IDLE.

Window evaluation:
- Evaluation happens when `(k+1) % WINDOW_SIZE == 0`.
- `cur` = accumulator + `|x|` for the current sample.
- Onset condition: `cur > prev` AND `cur > pp + (pp >> 1)` AND `cur >= MIN_ENERGY`.
  - `prev` = sum of the preceding window; `pp` = sum of the one before that. Both are 0 at start.
- On onset: the channel's detected flag is set and its delay becomes `k+1-WINDOW_SIZE` (first sample of the onset window). The channel is frozen from then on.
- Otherwise: `pp <= prev`, `prev <= cur`, accumulator cleared.

Exit conditions:
- Leave ANALYZE for REPORT when all channels are detected after an evaluation, or when k = `MAX_DELAY-1` has been processed (timeout).
- At timeout, undetected channels report valid=0 and delay=0.

Arithmetic:
- `|x|` is computed at `MIC_WIDTH` bits unsigned. The most negative input, -2^(MIC_WIDTH-1), maps to 2^(MIC_WIDTH-1) with no saturation.
- Accumulators and window sums are `MIC_WIDTH+$clog2(WINDOW_SIZE)` bits wide.
- The 1.5× term is computed one bit wider, so overflow is impossible.

## Timing
Reset values:
- `impulse_trigger_out`=0, `delay_out`=0, `delay_valid_out`=0, `done_out`=0, `busy_out`=0.
- State = IDLE. All internal counters and sums cleared.

Latency and handshake:
- `trigger_in` at cycle t → `impulse_trigger_out` at t+1 → WAIT_IMP from t+2.
- `impulse_done_in` at cycle t → ANALYZE from t+1. A `step_in` coinciding with `impulse_done_in` is ignored.
- The final `step_in` evaluated at cycle t → REPORT at t+1, so `done_out` and the new outputs appear at t+1.

Boundary rules:
- `trigger_in` while `busy_out`=1 is ignored.
- If a detection and the timeout occur on the same sample, the detection counts.
- `rst_in` mid-measurement returns to reset values on the next edge; no `done_out` is issued.
- `step_in` outside ANALYZE has no effect.

## Test plan
All scenarios use `NUM_CH`=2, `MIC_WIDTH`=8, `WINDOW_SIZE`=4, `MAX_DELAY`=32, `MIN_ENERGY`=16, with `impulse_done_in` driven 3 cycles after `impulse_trigger_out`.

1. **Silence.** All samples 0 → `done_out` one cycle after the 32nd `step_in`; `delay_valid_out`=00; delays 0.
2. **Staggered onsets.**
   - Stimulus: ch0 = 0 for samples 0–11, then 50. ch1 = 0 for samples 0–19, then -50.
   - Response: ch0 delay 12, ch1 delay 20, valid=11, `done_out` one cycle after sample 23.
3. **Gradual ramp on ch0 (ch1 silent).**
   - Stimulus: window sums 12, 15, 17, 19, then 20 for every later window.
   - Response: no window satisfies all three conditions (15<16; 17≯18; 19≯22; 20≯25); timeout with valid=00.
4. **Most-negative input.** ch0 = -128 from sample 0 → window sum 512; delay 0, valid bit 0 set; no overflow.
5. **Trigger during busy.** Pulse `trigger_in` during ANALYZE → no second `impulse_trigger_out`; exactly one `done_out`.
6. **Reset mid-measurement.** Assert `rst_in` during ANALYZE → all outputs at reset values; the next trigger runs a clean measurement matching scenario 2.
